// File: rtl/sd_emmc_sdma_pkg.sv
// sd_emmc_sdma_pkg: shared types and helpers for the SDMA engine.
// FSM states, AXI response codes, boundary and burst-length math.
package sd_emmc_sdma_pkg;

    typedef enum logic [3:0] {
        IDLE,
        W_WAIT,
        W_ADDR,
        W_DATA,
        W_RESP,
        R_WAIT,
        R_ADDR,
        R_DATA,
        BLK_CHECK,
        PAUSE,
        DONE
    } sdma_state_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam int BEAT_W = 9;

    // Byte mask of the SDMA buffer boundary (4 KiB << bb) - 1.
    function automatic logic [63:0] boundary_mask(input logic [2:0] bb);
        return (64'd4096 << bb) - 64'd1;
    endfunction

    // Beats = min(max burst, words left in block, words to next 4 KiB page).
    function automatic logic [BEAT_W-1:0] burst_len(
        input int unsigned max_b,
        input logic [31:0] words,
        input logic [11:0] addr_lo,
        input int unsigned bpw
    );
        int unsigned room;
        int unsigned b;
        room = (32'd4096 - {20'd0, addr_lo}) / bpw;
        b = max_b;
        if (words < b) b = words;
        if (room < b) b = room;
        return BEAT_W'(b);
    endfunction

endpackage

// File: rtl/sd_emmc_sdma_burst_calc.sv
// sd_emmc_sdma_burst_calc: combinational burst sizing.
// Produces the beat count for the next burst and the address after it.
module sd_emmc_sdma_burst_calc
    import sd_emmc_sdma_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 32,
    parameter int MAX_BURST = 16,
    parameter int BLKSZ_W   = 12
) (
    input  logic [ADDR_W-1:0]  addr,
    input  logic [BLKSZ_W-1:0] words_left,
    output logic [BEAT_W-1:0]  beats,
    output logic [ADDR_W-1:0]  next_addr
);

    localparam int BPW = DATA_W / 8;
    localparam int SZ  = $clog2(BPW);

    // Size the burst and advance the address by its byte length.
    always_comb begin
        beats     = burst_len(MAX_BURST, 32'(words_left), addr[11:0], BPW);
        next_addr = addr + (ADDR_W'(beats) << SZ);
    end

endmodule

// File: rtl/sd_emmc_sdma_engine.sv
// sd_emmc_sdma_engine: SDMA block mover between data FIFOs and AXI4 memory.
// Optional SDMA_AXI_ERR_EN adds dma_err and aborts on a non-OKAY response.
module sd_emmc_sdma_engine
    import sd_emmc_sdma_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 32,
    parameter int MAX_BURST  = 16,
    parameter int BLKCNT_W   = 16,
    parameter int BLKSZ_W    = 12,
    parameter int FIFO_CNT_W = 10
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  dir_rd,
    input  logic                  blk_count_ena,
    input  logic [BLKCNT_W-1:0]   block_count,
    input  logic [BLKSZ_W-1:0]    blk_size,
    input  logic [2:0]            buf_boundary,
    input  logic [ADDR_W-1:0]     sys_addr,
    input  logic                  sys_addr_wr,
    input  logic                  xfer_compl,
    input  logic                  abort,
    input  logic [1:0]            int_clr,
    output logic [1:0]            dma_int,
`ifdef SDMA_AXI_ERR_EN
    output logic                  dma_err,
`endif
    output logic                  busy,
    input  logic [FIFO_CNT_W-1:0] rx_level,
    output logic                  rx_rd_en,
    input  logic [DATA_W-1:0]     rx_data,
    input  logic [FIFO_CNT_W-1:0] tx_free,
    output logic                  tx_wr_en,
    output logic [DATA_W-1:0]     tx_data,
    output logic [ADDR_W-1:0]     m_awaddr,
    output logic [7:0]            m_awlen,
    output logic                  m_awvalid,
    input  logic                  m_awready,
    output logic [DATA_W-1:0]     m_wdata,
    output logic [DATA_W/8-1:0]   m_wstrb,
    output logic                  m_wlast,
    output logic                  m_wvalid,
    input  logic                  m_wready,
    input  logic [1:0]            m_bresp,
    input  logic                  m_bvalid,
    output logic                  m_bready,
    output logic [ADDR_W-1:0]     m_araddr,
    output logic [7:0]            m_arlen,
    output logic                  m_arvalid,
    input  logic                  m_arready,
    input  logic [DATA_W-1:0]     m_rdata,
    input  logic [1:0]            m_rresp,
    input  logic                  m_rlast,
    input  logic                  m_rvalid,
    output logic                  m_rready
);

    localparam int BPW = DATA_W / 8;
    localparam int SZ  = $clog2(BPW);

    sdma_state_t          state, nxt, wait_st;
    logic [ADDR_W-1:0]    addr, next_addr;
    logic [BLKSZ_W-1:0]   words_left, blk_words;
    logic [BLKCNT_W-1:0]  blk_done, blk_total;
    logic [BEAT_W-1:0]    beats, beat_cnt;
    logic [63:0]          bmask;
    logic                 cnt_ena, dir, abort_l, err_q;
    logic                 stop, finish, last_beat, burst_end;
    logic                 set_cmp, set_pause;
    logic                 unused_mask;

    sd_emmc_sdma_burst_calc #(
        .DATA_W    (DATA_W),
        .ADDR_W    (ADDR_W),
        .MAX_BURST (MAX_BURST),
        .BLKSZ_W   (BLKSZ_W)
    ) u_calc (
        .addr       (addr),
        .words_left (words_left),
        .beats      (beats),
        .next_addr  (next_addr)
    );

    assign bmask       = boundary_mask(buf_boundary);
    assign unused_mask = ^bmask[63:ADDR_W];
    assign wait_st     = dir ? W_WAIT : R_WAIT;
    assign stop        = abort_l | abort | err_q;
    assign finish      = ~cnt_ena & xfer_compl;
    assign last_beat   = (beat_cnt == beats - BEAT_W'(1));
    assign burst_end   = (state == W_RESP && m_bvalid) ||
                         (state == R_DATA && m_rvalid && m_rlast);

`ifdef SDMA_AXI_ERR_EN
    logic resp_bad, err_l;
    assign resp_bad = (m_bvalid && m_bready && m_bresp != RESP_OKAY) ||
                      (m_rvalid && m_rready && m_rresp != RESP_OKAY);
    assign err_q = err_l;

    // Error latch for the running transfer plus the sticky status bit.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            err_l   <= 1'b0;
            dma_err <= 1'b0;
        end else begin
            err_l   <= (state != IDLE) && (err_l || resp_bad);
            dma_err <= resp_bad | (dma_err & ~int_clr[1]);
        end
    end
`else
    logic unused_resp;
    assign unused_resp = ^{m_bresp, m_rresp};
    assign err_q = 1'b0;
`endif

    // State register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= nxt;
    end

    // Next-state decode and interrupt set strobes.
    always_comb begin
        nxt       = state;
        set_cmp   = 1'b0;
        set_pause = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    if (blk_count_ena && block_count == '0) nxt = DONE;
                    else nxt = dir_rd ? W_WAIT : R_WAIT;
                end
            end
            W_WAIT: begin
                if (stop) nxt = IDLE;
                else if (finish) begin
                    set_cmp = 1'b1;
                    nxt     = IDLE;
                end else if (32'(rx_level) >= 32'(beats)) nxt = W_ADDR;
            end
            W_ADDR: if (m_awready) nxt = W_DATA;
            W_DATA: if (m_wready && last_beat) nxt = W_RESP;
            W_RESP: if (m_bvalid) nxt = BLK_CHECK;
            R_WAIT: begin
                if (stop) nxt = IDLE;
                else if (finish) begin
                    set_cmp = 1'b1;
                    nxt     = IDLE;
                end else if (32'(tx_free) >= 32'(beats)) nxt = R_ADDR;
            end
            R_ADDR: if (m_arready) nxt = R_DATA;
            R_DATA: if (m_rvalid && m_rlast) nxt = BLK_CHECK;
            BLK_CHECK: begin
                if (stop) nxt = IDLE;
                else if (cnt_ena && blk_done == blk_total) nxt = DONE;
                else if ((addr & bmask[ADDR_W-1:0]) == '0) begin
                    set_pause = 1'b1;
                    nxt       = PAUSE;
                end else nxt = wait_st;
            end
            PAUSE: begin
                if (stop) nxt = IDLE;
                else if (finish) begin
                    set_cmp = 1'b1;
                    nxt     = IDLE;
                end else if (sys_addr_wr) nxt = wait_st;
            end
            DONE: begin
                if (stop) nxt = IDLE;
                else if (xfer_compl) begin
                    set_cmp = 1'b1;
                    nxt     = IDLE;
                end
            end
            default: nxt = IDLE;
        endcase
    end

    // Address, block and beat bookkeeping.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            addr       <= '0;
            words_left <= '0;
            blk_words  <= '0;
            blk_done   <= '0;
            blk_total  <= '0;
            beat_cnt   <= '0;
            cnt_ena    <= 1'b0;
            dir        <= 1'b0;
            abort_l    <= 1'b0;
        end else begin
            abort_l <= (state != IDLE) && (abort_l || abort);
            if (state == IDLE && start) begin
                addr       <= sys_addr;
                words_left <= blk_size >> SZ;
                blk_words  <= blk_size >> SZ;
                blk_done   <= '0;
                blk_total  <= block_count;
                cnt_ena    <= blk_count_ena;
                dir        <= dir_rd;
            end else if (state == PAUSE && nxt == wait_st) begin
                addr <= sys_addr;
            end else if (burst_end) begin
                addr <= next_addr;
                if (words_left == BLKSZ_W'(beats)) begin
                    words_left <= blk_words;
                    blk_done   <= blk_done + BLKCNT_W'(1);
                end else begin
                    words_left <= words_left - BLKSZ_W'(beats);
                end
            end
            if (state == W_ADDR) beat_cnt <= '0;
            else if (rx_rd_en)   beat_cnt <= beat_cnt + BEAT_W'(1);
        end
    end

    // Sticky interrupts; a same-cycle set beats the clear.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) dma_int <= 2'b00;
        else dma_int <= (dma_int & ~int_clr) | {set_pause, set_cmp};
    end

    assign busy      = (state != IDLE);
    assign m_awvalid = (state == W_ADDR);
    assign m_awaddr  = m_awvalid ? addr : '0;
    assign m_awlen   = m_awvalid ? 8'(beats - BEAT_W'(1)) : 8'd0;
    assign m_wvalid  = (state == W_DATA);
    assign m_wdata   = m_wvalid ? rx_data : '0;
    assign m_wstrb   = m_wvalid ? '1 : '0;
    assign m_wlast   = m_wvalid && last_beat;
    assign rx_rd_en  = m_wvalid && m_wready;
    assign m_bready  = (state == W_RESP);
    assign m_arvalid = (state == R_ADDR);
    assign m_araddr  = m_arvalid ? addr : '0;
    assign m_arlen   = m_arvalid ? 8'(beats - BEAT_W'(1)) : 8'd0;
    assign m_rready  = (state == R_DATA);
    assign tx_wr_en  = m_rready && m_rvalid;
    assign tx_data   = tx_wr_en ? m_rdata : '0;

endmodule

// File: tb/tb_sd_emmc_sdma_engine.sv
// tb_sd_emmc_sdma_engine: directed bench with AXI slave and FIFO models.
// Covers bursts, 4 KiB split, boundary pause, read stall, abort and reset.
module tb_sd_emmc_sdma_engine;
    import sd_emmc_sdma_pkg::*;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0, dir_rd = 1'b0, blk_count_ena = 1'b0;
    logic [15:0] block_count = '0;
    logic [11:0] blk_size = '0;
    logic [2:0]  buf_boundary = '0;
    logic [31:0] sys_addr = '0;
    logic        sys_addr_wr = 1'b0, xfer_compl = 1'b0, abort = 1'b0;
    logic [1:0]  int_clr = '0;
    logic [1:0]  dma_int;
    logic        dma_err;
    logic        busy, rx_rd_en, tx_wr_en;
    logic [9:0]  rx_level = 10'd1023;
    logic [9:0]  tx_free = 10'd1023;
    logic [31:0] rx_data, tx_data;
    logic [31:0] m_awaddr, m_araddr, m_wdata, m_rdata;
    logic [7:0]  m_awlen, m_arlen;
    logic [3:0]  m_wstrb;
    logic        m_awvalid, m_wlast, m_wvalid, m_bready, m_arvalid, m_rready;
    logic        m_awready = 1'b1, m_wready = 1'b1, m_arready = 1'b1;
    logic [1:0]  m_bresp, m_rresp;
    logic        m_bvalid, m_rvalid, m_rlast;

    int n_chk = 0, n_err = 0;
    int aw_n = 0, b_n = 0, ar_n = 0, tx_n = 0, tx_n0 = 0;
    int err_at = -1;
    int w_idx = 0, r_left = 0;
    logic [7:0]  cur_len = '0;
    logic [31:0] r_addr = '0, tx_base = '0, rx_word = '0;
    logic [31:0] aw_addr_log [0:255];
    logic [7:0]  aw_len_log  [0:255];
    logic [31:0] ar_addr_log [0:255];
    logic [7:0]  ar_len_log  [0:255];

    always #5 clock = ~clock;

    sd_emmc_sdma_engine dut (
        .clock(clock), .reset(reset), .start(start), .dir_rd(dir_rd),
        .blk_count_ena(blk_count_ena), .block_count(block_count),
        .blk_size(blk_size), .buf_boundary(buf_boundary),
        .sys_addr(sys_addr), .sys_addr_wr(sys_addr_wr),
        .xfer_compl(xfer_compl), .abort(abort), .int_clr(int_clr),
        .dma_int(dma_int),
`ifdef SDMA_AXI_ERR_EN
        .dma_err(dma_err),
`endif
        .busy(busy), .rx_level(rx_level), .rx_rd_en(rx_rd_en),
        .rx_data(rx_data), .tx_free(tx_free), .tx_wr_en(tx_wr_en),
        .tx_data(tx_data), .m_awaddr(m_awaddr), .m_awlen(m_awlen),
        .m_awvalid(m_awvalid), .m_awready(m_awready), .m_wdata(m_wdata),
        .m_wstrb(m_wstrb), .m_wlast(m_wlast), .m_wvalid(m_wvalid),
        .m_wready(m_wready), .m_bresp(m_bresp), .m_bvalid(m_bvalid),
        .m_bready(m_bready), .m_araddr(m_araddr), .m_arlen(m_arlen),
        .m_arvalid(m_arvalid), .m_arready(m_arready), .m_rdata(m_rdata),
        .m_rresp(m_rresp), .m_rlast(m_rlast), .m_rvalid(m_rvalid),
        .m_rready(m_rready)
    );

`ifndef SDMA_AXI_ERR_EN
    assign dma_err = 1'b0;
`endif

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // rx FIFO model: head is a running counter, popped on rx_rd_en.
    assign rx_data = rx_word;
    always @(posedge clock) if (rx_rd_en) rx_word <= rx_word + 1;

    // AXI write slave: always ready, one B response per burst.
    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            m_bvalid <= 1'b0;
            m_bresp  <= RESP_OKAY;
            w_idx = 0;
        end else begin
            if (m_bvalid && m_bready) begin
                m_bvalid <= 1'b0;
                b_n = b_n + 1;
            end
            if (m_awvalid && m_awready) begin
                aw_addr_log[aw_n] = m_awaddr;
                aw_len_log[aw_n]  = m_awlen;
                cur_len = m_awlen;
                aw_n = aw_n + 1;
                w_idx = 0;
            end
            if (m_wvalid && m_wready) begin
                check("wdata", m_wdata, rx_word);
                check("wlast", m_wlast, w_idx == int'(cur_len));
                check("wstrb", m_wstrb, 4'hF);
                if (m_wlast) begin
                    m_bvalid <= 1'b1;
                    m_bresp  <= (b_n == err_at) ? RESP_SLVERR : RESP_OKAY;
                end
                w_idx = w_idx + 1;
            end
        end
    end

    // AXI read slave: data pattern derived from the beat address.
    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            m_rvalid <= 1'b0;
            m_rlast  <= 1'b0;
            m_rdata  <= '0;
            m_rresp  <= RESP_OKAY;
            r_left = 0;
        end else begin
            if (m_rvalid && m_rready) begin
                r_left = r_left - 1;
                r_addr = r_addr + 4;
            end
            if (m_arvalid && m_arready) begin
                ar_addr_log[ar_n] = m_araddr;
                ar_len_log[ar_n]  = m_arlen;
                ar_n = ar_n + 1;
                r_addr = m_araddr;
                r_left = int'(m_arlen) + 1;
            end
            m_rvalid <= (r_left > 0);
            m_rlast  <= (r_left == 1);
            m_rdata  <= 32'hA500_0000 ^ r_addr;
        end
    end

    // tx FIFO checker: words must arrive in memory-address order.
    always @(posedge clock) begin
        if (reset && tx_wr_en) begin
            check("tx_data", tx_data,
                  32'hA500_0000 ^ (tx_base + 32'(4 * (tx_n - tx_n0))));
            tx_n = tx_n + 1;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic kick(input logic rd, input logic ena,
                        input logic [15:0] bc, input logic [11:0] bs,
                        input logic [2:0] bb, input logic [31:0] a);
        @(negedge clock);
        dir_rd = rd; blk_count_ena = ena; block_count = bc;
        blk_size = bs; buf_boundary = bb; sys_addr = a; start = 1'b1;
        @(negedge clock);
        start = 1'b0;
    endtask

    task automatic pulse_xfer();
        @(negedge clock); xfer_compl = 1'b1;
        @(negedge clock); xfer_compl = 1'b0;
    endtask

    task automatic pulse_clr(input logic [1:0] v);
        @(negedge clock); int_clr = v;
        @(negedge clock); int_clr = 2'b00;
    endtask

    task automatic wait_b(input int n);
        int k = 0;
        while (b_n < n && k < 4000) begin @(negedge clock); k++; end
        check("wait_b", b_n, n);
    endtask

    task automatic wait_aw(input int n);
        int k = 0;
        while (aw_n < n && k < 4000) begin @(negedge clock); k++; end
        check("wait_aw", aw_n, n);
    endtask

    task automatic wait_tx(input int n);
        int k = 0;
        while (tx_n < n && k < 4000) begin @(negedge clock); k++; end
        check("wait_tx", tx_n, n);
    endtask

    task automatic wait_idle();
        int k = 0;
        while (busy && k < 4000) begin @(negedge clock); k++; end
        check("wait_idle", busy, 0);
    endtask

    task automatic wait_wvalid();
        int k = 0;
        while (!m_wvalid && k < 200) begin @(negedge clock); k++; end
        check("in_wdata", m_wvalid, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int a0, b0, r0;
        logic seen;

        tick(3);
        check("rst_busy", busy, 0);
        check("rst_int", dma_int, 0);
        check("rst_awvalid", m_awvalid, 0);
        check("rst_arvalid", m_arvalid, 0);
        check("rst_wvalid", m_wvalid, 0);
        check("rst_rx_rd", rx_rd_en, 0);
        check("rst_tx_wr", tx_wr_en, 0);
        reset = 1'b1;
        tick(2);

        // Two 512-byte blocks to 0x1000: 16 full bursts.
        a0 = aw_n; b0 = b_n;
        kick(1, 1, 16'd2, 12'd512, 3'd0, 32'h1000);
        wait_b(b0 + 16);
        tick(5);
        check("t1_bursts", aw_n - a0, 16);
        for (int i = 0; i < 16; i++) begin
            check("t1_len", aw_len_log[a0 + i], 15);
            check("t1_addr", aw_addr_log[a0 + i], 32'h1000 + 64 * i);
        end
        check("t1_busy_done", busy, 1);
        check("t1_int_pre", dma_int, 2'b00);
        pulse_xfer();
        check("t1_int", dma_int, 2'b01);
        check("t1_idle", busy, 0);
        pulse_clr(2'b01);
        check("t1_clr", dma_int, 2'b00);

        // 64-byte block at 0x1FF8: split at the 4 KiB page.
        a0 = aw_n; b0 = b_n;
        kick(1, 1, 16'd1, 12'd64, 3'd7, 32'h1FF8);
        wait_b(b0 + 2);
        tick(5);
        check("t2_bursts", aw_n - a0, 2);
        check("t2_len0", aw_len_log[a0], 1);
        check("t2_addr0", aw_addr_log[a0], 32'h1FF8);
        check("t2_len1", aw_len_log[a0 + 1], 13);
        check("t2_addr1", aw_addr_log[a0 + 1], 32'h2000);
        pulse_xfer();
        check("t2_int", dma_int, 2'b01);
        pulse_clr(2'b01);

        // 4 KiB boundary pause after block 1, resume at 0x8000.
        a0 = aw_n; b0 = b_n;
        kick(1, 1, 16'd4, 12'd512, 3'd0, 32'h0E00);
        wait_b(b0 + 8);
        tick(10);
        check("t3_paused_bursts", aw_n - a0, 8);
        check("t3_pause_int", dma_int, 2'b10);
        check("t3_busy", busy, 1);
        pulse_clr(2'b10);
        check("t3_clr", dma_int, 2'b00);
        @(negedge clock); sys_addr = 32'h8000; sys_addr_wr = 1'b1;
        @(negedge clock); sys_addr_wr = 1'b0;
        wait_aw(a0 + 9);
        check("t3_resume_addr", aw_addr_log[a0 + 8], 32'h8000);
        wait_b(b0 + 32);
        tick(5);
        check("t3_total", aw_n - a0, 32);
        check("t3_last_addr", aw_addr_log[a0 + 31], 32'h85C0);
        check("t3_no_repause", dma_int, 2'b00);
        pulse_xfer();
        check("t3_int", dma_int, 2'b01);
        pulse_clr(2'b01);

        // Read path: stall on tx_free, start-while-busy ignored.
        r0 = ar_n; tx_n0 = tx_n; tx_base = 32'h3000;
        tx_free = 10'd8;
        kick(0, 1, 16'd1, 12'd64, 3'd0, 32'h3000);
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            if (m_arvalid) seen = 1'b1;
        end
        check("t4_ar_stall", seen, 0);
        check("t4_busy", busy, 1);
        a0 = aw_n;
        kick(1, 1, 16'd1, 12'd64, 3'd0, 32'h9000);
        tick(3);
        check("t4_start_ignored", aw_n - a0, 0);
        tx_free = 10'd16;
        wait_tx(tx_n0 + 16);
        tick(5);
        check("t4_bursts", ar_n - r0, 1);
        check("t4_arlen", ar_len_log[r0], 15);
        check("t4_araddr", ar_addr_log[r0], 32'h3000);
        check("t4_aw_none", aw_n - a0, 0);
        pulse_xfer();
        check("t4_int", dma_int, 2'b01);
        pulse_clr(2'b01);
        tx_free = 10'd1023;

        // Abort mid-burst: burst completes, then idle with no interrupt.
        a0 = aw_n; b0 = b_n;
        kick(1, 1, 16'd2, 12'd512, 3'd0, 32'h1000);
        wait_wvalid();
        tick(3);
        abort = 1'b1;
        @(negedge clock); abort = 1'b0;
        wait_idle();
        check("t5_aw", aw_n - a0, 1);
        check("t5_b", b_n - b0, 1);
        check("t5_int", dma_int, 2'b00);

        // Zero-size config goes straight to DONE.
        a0 = aw_n;
        kick(1, 1, 16'd0, 12'd512, 3'd0, 32'h5000);
        tick(5);
        check("t6_busy", busy, 1);
        check("t6_no_aw", aw_n - a0, 0);
        pulse_xfer();
        check("t6_int", dma_int, 2'b01);
        check("t6_idle", busy, 0);

        // Reset mid-burst clears every output at once.
        kick(1, 1, 16'd2, 12'd512, 3'd0, 32'h1000);
        wait_wvalid();
        tick(2);
        reset = 1'b0;
        #1;
        check("t7_busy", busy, 0);
        check("t7_wvalid", m_wvalid, 0);
        check("t7_wlast", m_wlast, 0);
        check("t7_rx_rd", rx_rd_en, 0);
        check("t7_bready", m_bready, 0);
        check("t7_int", dma_int, 2'b00);
        tick(2);
        reset = 1'b1;
        tick(2);

`ifdef SDMA_AXI_ERR_EN
        // SLVERR on the third burst stops the transfer.
        a0 = aw_n;
        err_at = b_n + 2;
        kick(1, 1, 16'd2, 12'd512, 3'd0, 32'h1000);
        wait_idle();
        check("t8_err", dma_err, 1);
        check("t8_aw", aw_n - a0, 3);
        check("t8_int", dma_int, 2'b00);
        pulse_clr(2'b10);
        check("t8_err_clr", dma_err, 0);
        err_at = -1;
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/sd_emmc_sdma_engine.md
Name: sd_emmc_sdma_engine

Overview:
Parametrised SDMA engine for the SD/eMMC host controller. It moves block data between the data-path FIFOs and system memory over an AXI4 master with variable-length bursts. Block size is programmable. SDMA buffer-boundary pause/resume follows SD Host Spec 3.00 §2.2.2. It sits between the S_AXI register file, the data serializer/deserializer FIFOs and the M_AXI port.

Parameters:
DATA_W, 32, AXI/FIFO data width in bits (32 or 64); BPW = DATA_W/8 bytes per word.
ADDR_W, 32, AXI address width.
MAX_BURST, 16, maximum beats per AXI burst (1..256).
BLKCNT_W, 16, block counter width.
BLKSZ_W, 12, block size field width in bytes.
FIFO_CNT_W, 10, width of the FIFO level inputs.

Ports:
clock  in  1  controller clock
reset  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse: begin transfer with the current config
dir_rd  in  1  1 = card->memory (AXI writes), 0 = memory->card (AXI reads)
blk_count_ena  in  1  1 = stop after block_count blocks; 0 = run until xfer_compl
block_count  in  BLKCNT_W  number of blocks
blk_size  in  BLKSZ_W  bytes per block; nonzero multiple of BPW
buf_boundary  in  3  SDMA boundary = 4 KiB << buf_boundary
sys_addr  in  ADDR_W  system address; BPW-aligned
sys_addr_wr  in  1  pulse: software wrote sys_addr
xfer_compl  in  1  card-side transfer complete
abort  in  1  serializer timeout/abort
int_clr  in  2  write-1-to-clear for dma_int
dma_int  out  2  sticky: [1] boundary pause, [0] transfer complete
busy  out  1  high when not IDLE
rx_level  in  FIFO_CNT_W  words available in card->memory FIFO
rx_rd_en  out  1  pop one rx word (same cycle as a W beat handshake)
rx_data  in  DATA_W  rx FIFO head
tx_free  in  FIFO_CNT_W  free words in memory->card FIFO
tx_wr_en  out  1  push one tx word
tx_data  out  DATA_W  word pushed
m_awaddr/awlen/awvalid/awready, m_wdata/wstrb/wlast/wvalid/wready, m_bresp/bvalid/bready, m_araddr/arlen/arvalid/arready, m_rdata/rresp/rlast/rvalid/rready: standard AXI4 INCR master signals, size = log2(BPW).

Behaviour:
- Reset (async, active-low): state IDLE; all outputs 0; all counters 0.
- States:
  - IDLE: on start, load addr = sys_addr and words_left_blk = blk_size/BPW, clear blk_done, then go to W_WAIT or R_WAIT.
  - W_WAIT: wait until rx_level >= beats, then go to W_ADDR.
  - W_ADDR: hold awvalid until awready.
  - W_DATA: each wvalid&wready handshake pops rx and counts down beats; wlast on the final beat.
  - W_RESP: bready = 1; on bvalid go to BLK_CHECK.
  - R_WAIT: wait until tx_free >= beats, then go to R_ADDR.
  - R_ADDR: hold arvalid until arready.
  - R_DATA: rready = 1; each beat pushes tx; on rlast go to BLK_CHECK.
  - BLK_CHECK: decide next state (see Completion and Boundary).
  - PAUSE: wait for software to write a new address.
  - DONE: wait for xfer_compl.
- Burst length: beats = min(MAX_BURST, words_left_blk, (4096 - addr[11:0])/BPW). Bursts never cross 4 KiB and never span two blocks. awlen/arlen = beats-1.
- Address: after each burst, addr += beats*BPW. Wrap at 2^ADDR_W.
- Completion: when a block's words reach 0, blk_done++. If blk_count_ena and blk_done == block_count, go to DONE. On xfer_compl, set dma_int[0] and return to IDLE. If blk_count_ena = 0, xfer_compl seen in any wait state also finishes.
- Boundary: at BLK_CHECK, if more blocks remain and (addr mod boundary) == 0, set dma_int[1] and enter PAUSE. sys_addr_wr in PAUSE loads addr and resumes to the wait state. sys_addr_wr in any other state is ignored.
- abort: latched. Takes effect at the next wait/PAUSE/DONE state or at burst end; an issued AXI burst always completes. Then go to IDLE with no interrupt.
- dma_int: a set and an int_clr on the same bit in the same cycle resolve as set-wins.
- start while busy: ignored.
- Zero-size config (block_count = 0 with blk_count_ena = 1): go straight to DONE.

Optional Feature:
SDMA_AXI_ERR_EN. When defined, adds output dma_err (sticky, cleared by int_clr[1]). Any bresp/rresp != OKAY sets dma_err; the engine finishes the current burst, then goes to IDLE without setting dma_int[0]. When undefined, responses are ignored and the port is absent.

Decomposition:
Shared package sd_emmc_sdma_pkg holds:
- the state enum;
- AXI resp constants (OKAY/SLVERR/DECERR);
- the boundary decode function (buf_boundary -> byte mask);
- the burst-length function.

One sub-module, sd_emmc_sdma_burst_calc, computes beats and next_addr combinationally.

Test Plan:
- dir_rd = 1, blk_size = 512, block_count = 2, DATA_W = 32, MAX_BURST = 16, sys_addr = 0x1000 -> 16 bursts of awlen = 15, final addr 0x1400, dma_int = 01 after xfer_compl.
- sys_addr = 0x1FF8, blk_size = 64, dir_rd = 1 -> first burst awlen = 1 (stops at 4 KiB), then awlen = 13, the remainder.
- buf_boundary = 0, sys_addr = 0x0E00, block_count = 4, blk_size = 512 -> pause after block 1 with dma_int[1] = 1; sys_addr_wr = 0x8000 resumes; next awaddr = 0x8000.
- dir_rd = 0, tx_free held at 8 -> no arvalid until tx_free >= 16; beats pushed to tx match m_rdata in order.
- abort asserted mid-W_DATA -> the burst completes with wlast and bresp, then IDLE with dma_int = 00; reset asserted mid-burst -> all outputs 0 immediately.
- SDMA_AXI_ERR_EN defined, bresp = SLVERR on burst 3 -> dma_err = 1, IDLE, dma_int[0] stays 0.
